// File: rtl/aes_word_host.sv
`default_nettype none
// ============================================================================
// Module  : aes_word_host
// Purpose : Serialises a 128-bit key/plaintext onto the aes_encrypt 32-bit
//           word interface and gathers the 4-word ciphertext back into 128 bits.
// Rev     : 1.0  initial release
// ============================================================================
module aes_word_host #(
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic         Clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [127:0] data_in,
    output logic         busy,
    output logic [127:0] result,
    output logic         result_valid,
    output logic         err_timeout,
    output logic [31:0]  core_key,
    output logic [31:0]  core_word,
    output logic         core_read,
    output logic         core_write,
    input  logic         core_done,
    input  logic [31:0]  core_buf
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_KEY  = 3'd1,
        LOAD_WORD = 3'd2,
        WAIT_DONE = 3'd3,
        DRAIN     = 3'd4,
        READ      = 3'd5
    } state_t;

    localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);
    localparam logic [2:0]  DRAIN_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    state_t       state;
    logic [1:0]   word_idx;
    logic [15:0]  wait_cnt;
    logic [2:0]   drain_cnt;
    logic [95:0]  key_sh;
    logic [127:0] data_sh;
    logic [95:0]  shadow;

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            word_idx     <= 2'd0;
            wait_cnt     <= 16'd0;
            drain_cnt    <= 3'd0;
            key_sh       <= '0;
            data_sh      <= '0;
            shadow       <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            err_timeout  <= 1'b0;
            core_key     <= '0;
            core_word    <= '0;
            core_read    <= 1'b0;
            core_write   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            err_timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // The first key word goes straight out; the rest are shifted up.
                        state     <= LOAD_KEY;
                        busy      <= 1'b1;
                        core_read <= 1'b1;
                        core_key  <= key_in[127:96];
                        key_sh    <= key_in[95:0];
                        data_sh   <= data_in;
                        word_idx  <= 2'd0;
                    end
                end
                LOAD_KEY: begin
                    if (word_idx == 2'd3) begin
                        state     <= LOAD_WORD;
                        core_word <= data_sh[127:96];
                        data_sh   <= {data_sh[95:0], 32'd0};
                        word_idx  <= 2'd0;
                    end else begin
                        core_key <= key_sh[95:64];
                        key_sh   <= {key_sh[63:0], 32'd0};
                        word_idx <= word_idx + 2'd1;
                    end
                end
                LOAD_WORD: begin
                    if (word_idx == 2'd3) begin
                        state     <= WAIT_DONE;
                        core_read <= 1'b0;
                        wait_cnt  <= 16'd0;
                        word_idx  <= 2'd0;
                    end else begin
                        core_word <= data_sh[127:96];
                        data_sh   <= {data_sh[95:0], 32'd0};
                        word_idx  <= word_idx + 2'd1;
                    end
                end
                WAIT_DONE: begin
                    if (core_done) begin
                        core_write <= 1'b1;
                        drain_cnt  <= DRAIN_INIT;
                        state      <= (RD_LAT == 1) ? READ : DRAIN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        state <= READ;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                READ: begin
                    shadow <= {shadow[63:0], core_buf};
                    if (word_idx == 2'd3) begin
                        // Publish only complete ciphertext so aborted runs never leak.
                        result       <= {shadow, core_buf};
                        result_valid <= 1'b1;
                        core_write   <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        word_idx <= word_idx + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_word_host.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_word_host
// Purpose : Self-checking bench; three hosts (RD_LAT 2/1/4) each driving a
//           behavioural core, compared against a transaction-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_aes_word_host;

    localparam int N   = 3;
    localparam int TMO = 20;
    localparam int LATS [N] = '{2, 1, 4};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         core_done;
    logic [127:0] key_in;
    logic [127:0] data_in;

    wire          busy         [N];
    wire  [127:0] result       [N];
    wire          result_valid [N];
    wire          err_timeout  [N];
    wire  [31:0]  core_key     [N];
    wire  [31:0]  core_word    [N];
    wire  [31:0]  core_buf     [N];
    wire          core_read    [N];
    wire          core_write   [N];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rv_cnt  [N] = '{0, 0, 0};
    int rv_edge [N] = '{0, 0, 0};
    int to_cnt    = 0;
    int to_edge   = 0;
    int rd_cycles = 0;
    int wr_cycles = 0;
    logic [127:0] exp_res;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the cipher: order-sensitive so swapped or shifted words show up.
    function automatic logic [127:0] cipher_model(input logic [127:0] k, input logic [127:0] d);
        return (k ^ d) + 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    endfunction

    function automatic logic [31:0] pick_word(input logic [127:0] ct, input int idx);
        logic [127:0] t;
        if (idx < 0 || idx > 3) return 32'hDEAD_0000 + 32'(idx);
        t = ct << (32 * idx);
        return t[127:96];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_lane
        int           rd_n;
        int           wr_n;
        logic [127:0] cap_key;
        logic [127:0] cap_data;
        wire  [127:0] ct = cipher_model(cap_key, cap_data);

        aes_word_host #(.RD_LAT(LATS[g]), .TIMEOUT(TMO)) dut (
            .Clk          (clk),
            .rst          (rst),
            .start        (start),
            .key_in       (key_in),
            .data_in      (data_in),
            .busy         (busy[g]),
            .result       (result[g]),
            .result_valid (result_valid[g]),
            .err_timeout  (err_timeout[g]),
            .core_key     (core_key[g]),
            .core_word    (core_word[g]),
            .core_read    (core_read[g]),
            .core_write   (core_write[g]),
            .core_done    (core_done),
            .core_buf     (core_buf[g])
        );

        // Core takes key words on the first 4 read edges, data on the next 4.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_n <= 0;
                wr_n <= 0;
            end else begin
                if (core_read[g]) begin
                    rd_n <= rd_n + 1;
                    if (rd_n < 4) cap_key  <= {cap_key[95:0], core_key[g]};
                    else          cap_data <= {cap_data[95:0], core_word[g]};
                end else begin
                    rd_n <= 0;
                end
                wr_n <= core_write[g] ? wr_n + 1 : 0;
            end
        end

        assign core_buf[g] = pick_word(ct, wr_n - (LATS[g] - 1));
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (result_valid[i]) begin
                rv_cnt[i]  <= rv_cnt[i] + 1;
                rv_edge[i] <= cyc - 1;
            end
        end
        if (err_timeout[0]) begin
            to_cnt  <= to_cnt + 1;
            to_edge <= cyc - 1;
        end
        if (core_read[0])  rd_cycles <= rd_cycles + 1;
        if (core_write[0]) wr_cycles <= wr_cycles + 1;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy[0] || busy[1] || busy[2]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_bound", 128'(n < 200), 128'(1));
    endtask

    // dly = edges after core_read falls at which done is sampled; 0 = never.
    task automatic do_run(input logic [127:0] k, input logic [127:0] d, input int dly);
        int e0;
        int n;
        int rv0 [N];
        int to0;
        int rd0;
        int wr0;
        wait_idle();
        @(negedge clk);
        key_in  = k;
        data_in = d;
        start   = 1'b1;
        for (int i = 0; i < N; i++) rv0[i] = rv_cnt[i];
        to0 = to_cnt;
        rd0 = rd_cycles;
        wr0 = wr_cycles;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc - 1;
        check_eq("accept_busy", 128'(busy[0]), 128'(1));
        check_eq("accept_read", 128'(core_read[0]), 128'(1));
        check_eq("accept_key", 128'(core_key[0]), 128'(k[127:96]));
        n = 0;
        while (core_read[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (dly > 0) begin
            repeat (dly - 1) @(negedge clk);
            core_done = 1'b1;
            @(negedge clk);
            core_done = 1'b0;
        end
        wait_idle();
        repeat (2) @(negedge clk);
        check_eq("bus_key", g_lane[0].cap_key, k);
        check_eq("bus_data", g_lane[0].cap_data, d);
        check_eq("read_cycles", 128'(rd_cycles - rd0), 128'(8));
        if (dly > 0) begin
            exp_res = cipher_model(k, d);
            check_eq("write_cycles", 128'(wr_cycles - wr0), 128'(LATS[0] + 3));
        end else begin
            check_eq("timeout_pulses", 128'(to_cnt - to0), 128'(1));
            check_eq("timeout_edge", 128'(to_edge - e0), 128'(8 + TMO));
            check_eq("timeout_write", 128'(wr_cycles - wr0), 128'(0));
        end
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("result[%0d]", i), result[i], exp_res);
            check_eq($sformatf("valid_pulses[%0d]", i), 128'(rv_cnt[i] - rv0[i]), 128'(dly > 0));
            if (dly > 0)
                check_eq($sformatf("latency[%0d]", i), 128'(rv_edge[i] - e0),
                         128'(8 + dly + LATS[i] + 3));
        end
    endtask

    task automatic held_start(input logic [127:0] k, input logic [127:0] d);
        int n_acc  = 0;
        int fall_e = -1;
        int n      = 0;
        int rv0;
        logic prev;
        wait_idle();
        @(negedge clk);
        key_in    = k;
        data_in   = d;
        core_done = 1'b1;
        start     = 1'b1;
        rv0       = rv_cnt[0];
        prev      = busy[0];
        while (n_acc < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (busy[0] && !prev) begin
                n_acc++;
                if (n_acc > 1) check_eq("accept_gap", 128'(cyc - 1), 128'(fall_e + 1));
                if (n_acc == 3) start = 1'b0;
            end
            if (!busy[0] && prev) fall_e = cyc - 1;
            prev = busy[0];
        end
        start = 1'b0;
        check_eq("held_accepts", 128'(n_acc), 128'(3));
        wait_idle();
        core_done = 1'b0;
        repeat (2) @(negedge clk);
        exp_res = cipher_model(k, d);
        check_eq("held_valid_pulses", 128'(rv_cnt[0] - rv0), 128'(3));
        check_eq("held_result", result[0], exp_res);
    endtask

    task automatic reset_mid_read();
        int n = 0;
        int rv0;
        wait_idle();
        @(negedge clk);
        key_in  = rnd128();
        data_in = rnd128();
        start   = 1'b1;
        rv0     = rv_cnt[0];
        @(negedge clk);
        start = 1'b0;
        while (core_read[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check_eq("write_rise", 128'(core_write[0]), 128'(1));
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("rst_result[%0d]", i), result[i], 128'(0));
            check_eq($sformatf("rst_ctrl[%0d]", i),
                     128'({busy[i], result_valid[i], err_timeout[i], core_key[i],
                           core_word[i], core_read[i], core_write[i]}), 128'(0));
        end
        @(negedge clk);
        rst     = 1'b0;
        exp_res = '0;
        repeat (6) @(negedge clk);
        check_eq("rst_no_valid", 128'(rv_cnt[0] - rv0), 128'(0));
        check_eq("rst_result_hold", result[0], exp_res);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        core_done = 1'b0;
        key_in    = '0;
        data_in   = '0;
        exp_res   = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_result", result[0], 128'(0));
        check_eq("reset_ctrl", 128'({busy[0], result_valid[0], err_timeout[0], core_key[0],
                                     core_word[0], core_read[0], core_write[0]}), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        do_run(128'h0, 128'h58c8e00b_2631686d_54eab84b_91f0aca1, 10);
        do_run(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, rnd128(), 1);
        repeat (4) do_run(rnd128(), rnd128(), int'($urandom_range(1, 15)));
        held_start(rnd128(), rnd128());
        do_run(rnd128(), rnd128(), 0);
        reset_mid_read();
        do_run(rnd128(), rnd128(), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
